// File: rtl/contador_modn_cascata_pkg.sv
// Shared constants, direction type and load clamping for the cascaded counter.
// Imported by the digit cell and the top level.
package contador_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int MOD_DEF     = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Out-of-range load values saturate to the largest legal digit.
    function automatic int unsigned clamp_digit(
        input int unsigned v,
        input int unsigned mod
    );
        return (v >= mod) ? mod - 1 : v;
    endfunction

endpackage

// File: rtl/contador_modn_cascata_if.sv
// Counter control/status bundle.
// master drives loadn/enable/up/data; slave returns count/tc/zero/done.
interface contador_modn_cascata_if #(
    parameter int NUM_DIGITS = 2,
    parameter int DIGIT_W    = 4
);
    logic                          loadn;
    logic                          enable;
    logic                          up;
    logic [NUM_DIGITS*DIGIT_W-1:0] data;
    logic [NUM_DIGITS*DIGIT_W-1:0] count;
    logic                          tc;
    logic                          zero;
    logic                          done;

    modport master (
        output loadn, enable, up, data,
        input  count, tc, zero, done
    );

    modport slave (
        input  loadn, enable, up, data,
        output count, tc, zero, done
    );
endinterface

// File: rtl/contador_modn_cascata_digito.sv
// One modulo-MOD digit: clr > load > step, wraps in either direction.
// Ports: clock, clr, load, step_in, up, data -> value, at_min, at_max.
module contador_digito
    import contador_pkg::*;
#(
    parameter int MOD     = MOD_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clock,
    input  logic               clr,
    input  logic               load,
    input  logic               step_in,
    input  logic               up,
    input  logic [DIGIT_W-1:0] data,
    output logic [DIGIT_W-1:0] value,
    output logic               at_min,
    output logic               at_max
);
    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - 1);

    dir_e               dir;
    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] load_val;
    logic [DIGIT_W-1:0] nxt;

    assign dir      = dir_e'(up);
    assign load_val = DIGIT_W'(clamp_digit(32'(data), MOD));
    assign at_min   = (value_q == '0);
    assign at_max   = (value_q == TOP);
    assign value    = value_q;

    always_comb begin
        nxt = value_q;
        if (dir == DIR_UP)
            nxt = at_max ? '0 : value_q + DIGIT_W'(1);
        else
            nxt = at_min ? TOP : value_q - DIGIT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (clr)
            value_q <= '0;
        else if (load)
            value_q <= load_val;
        else if (step_in)
            value_q <= nxt;
    end
endmodule

// File: rtl/contador_modn_cascata.sv
// N-digit cascaded modulo up/down counter with clamped load and tc/zero flags.
// Ports: clock, clr (sync, active high), bus (slave). Macro CONTADOR_SATURA_EN
// makes the counter hold at its terminal value and raise done instead of wrapping.
module contador_modn_cascata
    import contador_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MOD        = MOD_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF
) (
    input logic                   clock,
    input logic                   clr,
    contador_modn_cascata_if.slave bus
);
    logic [NUM_DIGITS-1:0]         at_min;
    logic [NUM_DIGITS-1:0]         at_max;
    logic [NUM_DIGITS-1:0]         step;
    logic [NUM_DIGITS:0]           chain;
    logic [NUM_DIGITS*DIGIT_W-1:0] count_w;
    logic                          tc_i;
    logic                          hold;

    // chain[i]: every digit below i sits at its carry/borrow value now.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign chain[i+1] = chain[i] & (bus.up ? at_max[i] : at_min[i]);
        assign step[i]    = bus.enable & chain[i] & ~hold;

        contador_digito #(
            .MOD     (MOD),
            .DIGIT_W (DIGIT_W)
        ) u_dig (
            .clock   (clock),
            .clr     (clr),
            .load    (~bus.loadn),
            .step_in (step[i]),
            .up      (bus.up),
            .data    (bus.data[i*DIGIT_W +: DIGIT_W]),
            .value   (count_w[i*DIGIT_W +: DIGIT_W]),
            .at_min  (at_min[i]),
            .at_max  (at_max[i])
        );
    end

    assign tc_i      = bus.enable & chain[NUM_DIGITS];
    assign bus.tc    = tc_i;
    assign bus.zero  = ~|count_w;
    assign bus.count = count_w;

`ifdef CONTADOR_SATURA_EN
    logic done_q;

    // A full-counter wrap is suppressed; load or clr releases it.
    assign hold = tc_i;

    always_ff @(posedge clock) begin
        if (clr)
            done_q <= 1'b0;
        else if (!bus.loadn)
            done_q <= 1'b0;
        else if (tc_i)
            done_q <= 1'b1;
    end

    assign bus.done = done_q;
`else
    assign hold     = 1'b0;
    assign bus.done = 1'b0;
`endif
endmodule

// File: tb/tb_contador_modn_cascata.sv
// Table, hand-sequence and random checks of contador_modn_cascata.
// Two DUTs share stimulus: MOD=10 and MOD=6, both NUM_DIGITS=2.
module tb_contador_modn_cascata;
    logic clock = 1'b0;
    logic clr   = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    always #5 clock = ~clock;

    contador_modn_cascata_if #(.NUM_DIGITS(2), .DIGIT_W(4)) ifa ();
    contador_modn_cascata_if #(.NUM_DIGITS(2), .DIGIT_W(4)) ifb ();

    contador_modn_cascata #(.NUM_DIGITS(2), .MOD(10), .DIGIT_W(4)) dut_a (
        .clock (clock), .clr (clr), .bus (ifa.slave)
    );
    contador_modn_cascata #(.NUM_DIGITS(2), .MOD(6), .DIGIT_W(4)) dut_b (
        .clock (clock), .clr (clr), .bus (ifb.slave)
    );

`ifdef CONTADOR_SATURA_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Model state: counter value as a plain integer in 0..MOD*MOD-1.
    int   ma = 0, mb = 0;
    logic da = 0, db = 0;
    logic tca, tcb;

    function automatic int to_int(logic [7:0] p, int mod);
        return int'(p[7:4]) * mod + int'(p[3:0]);
    endfunction

    function automatic logic [7:0] to_pack(int v, int mod);
        return {4'(v / mod), 4'(v % mod)};
    endfunction

    function automatic int load_int(logic [7:0] d, int mod);
        int hi, lo;
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        if (hi >= mod) hi = mod - 1;
        if (lo >= mod) lo = mod - 1;
        return hi * mod + lo;
    endfunction

    function automatic logic model_tc(int v, int mod, logic e, logic u);
        return e && (u ? (v == mod * mod - 1) : (v == 0));
    endfunction

    task automatic model_next(inout int v, inout logic dn, input int mod,
                              input logic c, l, e, u, input logic [7:0] d);
        int tot;
        tot = mod * mod;
        if (c) begin
            v  = 0;
            dn = 0;
        end else if (!l) begin
            v  = load_int(d, mod);
            dn = 0;
        end else if (e) begin
            if (SAT && model_tc(v, mod, e, u))
                dn = 1;
            else
                v = u ? (v + 1) % tot : (v + tot - 1) % tot;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, l, e, u, input logic [7:0] d);
        @(negedge clock);
        clr        = c;
        ifa.loadn  = l; ifa.enable = e; ifa.up = u; ifa.data = d;
        ifb.loadn  = l; ifb.enable = e; ifb.up = u; ifb.data = d;
        #1;
        tca = ifa.tc;
        tcb = ifb.tc;
        chk("tc_a",   32'(ifa.tc),   32'(model_tc(ma, 10, e, u)));
        chk("tc_b",   32'(ifb.tc),   32'(model_tc(mb, 6, e, u)));
        chk("zero_a", 32'(ifa.zero), 32'(ma == 0));
        chk("zero_b", 32'(ifb.zero), 32'(mb == 0));
        model_next(ma, da, 10, c, l, e, u, d);
        model_next(mb, db, 6, c, l, e, u, d);
        @(posedge clock);
        #1;
        chk("count_a", 32'(ifa.count), 32'(to_pack(ma, 10)));
        chk("count_b", 32'(ifb.count), 32'(to_pack(mb, 6)));
        chk("done_a",  32'(ifa.done),  32'(da));
        chk("done_b",  32'(ifb.done),  32'(db));
    endtask

    typedef struct {
        logic       c, l, e, u;
        logic [7:0] d;
        logic [7:0] exp;
        logic       exp_tc;
    } vec_t;

    localparam logic [7:0] WRAP_DN = SAT ? 8'h00 : 8'h99;
    localparam logic [7:0] WRAP_UP = SAT ? 8'h99 : 8'h00;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 8'h57, 8'h57, 0};
        tbl[1]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0};
        tbl[2]  = '{1, 0, 1, 0, 8'h33, 8'h00, 1};
        tbl[3]  = '{0, 1, 1, 0, 8'h00, WRAP_DN, 1};
        tbl[4]  = '{0, 0, 0, 0, 8'h10, 8'h10, 0};
        tbl[5]  = '{0, 1, 1, 0, 8'h00, 8'h09, 0};
        tbl[6]  = '{0, 0, 1, 0, 8'h37, 8'h37, 0};
        tbl[7]  = '{0, 1, 1, 0, 8'h00, 8'h36, 0};
        tbl[8]  = '{0, 1, 1, 0, 8'h00, 8'h35, 0};
        tbl[9]  = '{0, 1, 1, 0, 8'h00, 8'h34, 0};
        tbl[10] = '{0, 0, 0, 0, 8'hA5, 8'h95, 0};
        tbl[11] = '{0, 0, 0, 1, 8'h98, 8'h98, 0};
        tbl[12] = '{0, 1, 1, 1, 8'h00, 8'h99, 0};
        tbl[13] = '{0, 1, 1, 1, 8'h00, WRAP_UP, 1};
        tbl[14] = '{0, 0, 0, 0, 8'h42, 8'h42, 0};

        ifa.loadn = 1; ifa.enable = 0; ifa.up = 0; ifa.data = '0;
        ifb.loadn = 1; ifb.enable = 0; ifb.up = 0; ifb.data = '0;

        step(1, 1, 0, 0, 8'h00);
        chk("rst_count", 32'(ifa.count), 32'h00);
        chk("rst_zero",  32'(ifa.zero),  32'h1);
        chk("rst_done",  32'(ifa.done),  32'h0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 32'(ifa.count), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_tc", i), 32'(tca), 32'(tbl[i].exp_tc));
        end

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, i[0], 8'h00);
            chk("hold_count", 32'(ifa.count), 32'h42);
            chk("hold_tc", 32'(tca), 32'h0);
        end

        step(0, 0, 0, 0, 8'h40);
        step(0, 1, 1, 1, 8'h00);
        chk("alt1", 32'(ifa.count), 32'h41);
        step(0, 1, 1, 0, 8'h00);
        chk("alt2", 32'(ifa.count), 32'h40);
        step(0, 1, 1, 1, 8'h00);
        chk("alt3", 32'(ifa.count), 32'h41);

        step(0, 0, 0, 1, 8'h55);
        step(0, 1, 1, 1, 8'h00);
        chk("mod6_tc", 32'(tcb), 32'h1);
        chk("mod6_wrap", 32'(ifb.count), SAT ? 32'h55 : 32'h00);

        step(0, 0, 0, 0, 8'h01);
        step(0, 1, 1, 0, 8'h00);
        chk("sat_a0", 32'(ifa.count), 32'h00);
        chk("sat_d0", 32'(ifa.done), 32'h0);
        step(0, 1, 1, 0, 8'h00);
        chk("sat_a1", 32'(ifa.count), SAT ? 32'h00 : 32'h99);
        chk("sat_d1", 32'(ifa.done), 32'(SAT));
        step(0, 0, 0, 0, 8'h05);
        chk("sat_ld", 32'(ifa.count), 32'h05);
        chk("sat_dl", 32'(ifa.done), 32'h0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
